// File: rtl/pdm_spkr_pkg.sv
// Shared helpers for the multi-channel PDM speaker driver: mid-scale code,
// offset-binary/two's-complement conversion and underrun counter sizing.
package pdm_spkr_pkg;

    localparam int unsigned MAX_W = 32;

    function automatic logic [MAX_W-1:0] mid_code(input int unsigned w);
        return MAX_W'(1) << (w - 1);
    endfunction

    // Offset-binary and two's complement differ only in the MSB, so one flip converts both ways.
    function automatic logic [MAX_W-1:0] flip_msb(input logic [MAX_W-1:0] x, input int unsigned w);
        return x ^ mid_code(w);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : int'($clog2(timeout + 1));
    endfunction

endpackage

// File: rtl/pdm_mod.sv
// First-order sigma-delta modulator: the carry out of acc + duty is the PDM bit.
module pdm_mod #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] duty,
    output logic         pdm
);

    logic [W-1:0] acc;
    logic [W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, duty};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            pdm <= 1'b0;
        end else begin
            acc <= sum[W-1:0];
            pdm <= sum[W];
        end
    end

endmodule

// File: rtl/pdm_spkr_drv_mc.sv
// Multi-channel PDM speaker driver: frame capture, sample conditioning
// (centring, attenuation, mute/underrun silence) and per-channel modulators.
module pdm_spkr_drv_mc
    import pdm_spkr_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned W         = 16,
    parameter bit          SIGNED_IN = 1'b0,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH*W-1:0] smp,
    input  logic                vld,
    input  logic [3:0]          atten,
    input  logic                mute,
    output logic [NUM_CH-1:0]   pdm,
    output logic                underrun
);

    localparam logic [W-1:0] MID     = W'(mid_code(W));
    localparam logic [W-1:0] SMP_RST = SIGNED_IN ? '0 : MID;

    logic [NUM_CH-1:0][W-1:0] sample;
    logic [NUM_CH-1:0][W-1:0] duty;
    logic [NUM_CH-1:0][W-1:0] duty_nxt;

    // Stage 1: frame capture
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NUM_CH); k++) sample[k] <= SMP_RST;
        end else if (vld) begin
            for (int k = 0; k < int'(NUM_CH); k++) sample[k] <= smp[k*W +: W];
        end
    end

    // Stage 2: centre, attenuate, return to offset-binary, silence on mute/underrun
    always_comb begin
        logic signed [W-1:0] c;
        logic signed [W-1:0] a;
        duty_nxt = '0;
        c        = '0;
        a        = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            c = SIGNED_IN ? sample[k] : W'(flip_msb(MAX_W'(sample[k]), W));
            a = c >>> atten;
            duty_nxt[k] = (mute || underrun) ? MID : W'(flip_msb(MAX_W'(a), W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NUM_CH); k++) duty[k] <= MID;
        end else begin
            duty <= duty_nxt;
        end
    end

    // Underrun detection: counts idle cycles since the last frame, saturating at TIMEOUT
    generate
        if (TIMEOUT > 0) begin : g_underrun
            localparam int unsigned CW = cnt_width(TIMEOUT);
            localparam logic [CW-1:0] TO = CW'(TIMEOUT);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt      <= '0;
                    underrun <= 1'b0;
                end else begin
                    if (vld) begin
                        cnt <= '0;
                    end else if (cnt != TO) begin
                        cnt <= cnt + CW'(1);
                    end
                    underrun <= (cnt == TO) && !vld;
                end
            end
        end else begin : g_no_underrun
            assign underrun = 1'b0;
        end
    endgenerate

    // Stage 3: one modulator per channel
    generate
        for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_ch
            pdm_mod #(.W(W)) u_mod (
                .clk  (clk),
                .rst  (rst),
                .duty (duty[k]),
                .pdm  (pdm[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pdm_spkr_drv_mc.sv
// Directed bench for pdm_spkr_drv_mc: an unsigned two-channel instance with a short
// timeout and a signed single-channel instance with underrun detection disabled.
module tb_pdm_spkr_drv_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] smp;
    logic        vld;
    logic [3:0]  atten;
    logic        mute;
    logic [1:0]  pdm;
    logic        underrun;

    logic [15:0] smp_s;
    logic        vld_s;
    logic [0:0]  pdm_s;
    logic        underrun_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pdm_spkr_drv_mc #(.NUM_CH(2), .W(16), .SIGNED_IN(1'b0), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .smp      (smp),
        .vld      (vld),
        .atten    (atten),
        .mute     (mute),
        .pdm      (pdm),
        .underrun (underrun)
    );

    pdm_spkr_drv_mc #(.NUM_CH(1), .W(16), .SIGNED_IN(1'b1), .TIMEOUT(0)) dut_s (
        .clk      (clk),
        .rst      (rst),
        .smp      (smp_s),
        .vld      (vld_s),
        .atten    (atten),
        .mute     (mute),
        .pdm      (pdm_s),
        .underrun (underrun_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_ones(input int n, output int o0, output int o1, output int os);
        o0 = 0;
        o1 = 0;
        os = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            o0 += int'(pdm[0]);
            o1 += int'(pdm[1]);
            os += int'(pdm_s[0]);
        end
    endtask

    int o0, o1, os;

    initial begin
        rst   = 1'b1;
        vld   = 1'b0;
        smp   = '0;
        atten = 4'd0;
        mute  = 1'b0;
        vld_s = 1'b0;
        smp_s = '0;
        tick();
        tick();

        // Reset state
        chk("rst_pdm", 32'(pdm), 32'h0);
        chk("rst_underrun", 32'(underrun), 32'h0);
        chk("rst_duty0", 32'(dut.duty[0]), 32'h8000);
        chk("rst_duty1", 32'(dut.duty[1]), 32'h8000);
        chk("rst_duty_s", 32'(dut_s.duty[0]), 32'h8000);

        // Silence from acc=0 toggles 0,1,0,1 on every channel
        rst = 1'b0;
        tick(); chk("mid_seq0", 32'({pdm_s, pdm}), 32'h0);
        tick(); chk("mid_seq1", 32'({pdm_s, pdm}), 32'h7);
        tick(); chk("mid_seq2", 32'({pdm_s, pdm}), 32'h0);
        tick(); chk("mid_seq3", 32'({pdm_s, pdm}), 32'h7);
        chk("mid_underrun", 32'(underrun), 32'h0);

        // Full-scale extremes; vld held so the short timeout never fires
        smp = {16'hFFFF, 16'h0000};
        vld = 1'b1;
        tick();
        tick();
        chk("ext_duty0", 32'(dut.duty[0]), 32'h0000);
        chk("ext_duty1", 32'(dut.duty[1]), 32'hFFFF);
        tick();
        count_ones(65536, o0, o1, os);
        chk("ext_ones0", 32'(o0), 32'd0);
        chk("ext_ones1", 32'(o1), 32'd65535);

        // Attenuation on positive and negative centred samples
        smp = {16'h4000, 16'hC000};
        tick();
        tick();
        chk("att0_duty0", 32'(dut.duty[0]), 32'hC000);
        chk("att0_duty1", 32'(dut.duty[1]), 32'h4000);
        tick();
        count_ones(1024, o0, o1, os);
        chk("att0_ones0", 32'(o0), 32'd768);
        chk("att0_ones1", 32'(o1), 32'd256);
        atten = 4'd1;
        tick();
        chk("att1_duty0", 32'(dut.duty[0]), 32'hA000);
        chk("att1_duty1", 32'(dut.duty[1]), 32'h6000);
        tick();
        count_ones(1024, o0, o1, os);
        chk("att1_ones0", 32'(o0), 32'd640);
        chk("att1_ones1", 32'(o1), 32'd384);
        atten = 4'd15;
        tick();
        chk("att15_duty0", 32'(dut.duty[0]), 32'h8000);
        chk("att15_duty1", 32'(dut.duty[1]), 32'h7FFF);

        // Signed input path
        atten = 4'd2;
        smp_s = 16'h8000;
        vld_s = 1'b1;
        tick();
        tick();
        chk("sgn_neg_duty", 32'(dut_s.duty[0]), 32'h6000);
        tick();
        count_ones(1024, o0, o1, os);
        chk("sgn_neg_ones", 32'(os), 32'd384);
        atten = 4'd0;
        smp_s = 16'h7FFF;
        tick();
        tick();
        chk("sgn_pos_duty", 32'(dut_s.duty[0]), 32'hFFFF);
        chk("sgn_underrun", 32'(underrun_s), 32'h0);
        vld_s = 1'b0;

        // Mute forces silence one edge later and releases the same way
        smp = {16'h4000, 16'hC000};
        tick();
        tick();
        chk("pre_mute_duty0", 32'(dut.duty[0]), 32'hC000);
        mute = 1'b1;
        tick();
        chk("mute_duty0", 32'(dut.duty[0]), 32'h8000);
        chk("mute_duty1", 32'(dut.duty[1]), 32'h8000);
        repeat (9) tick();
        chk("mute_hold_duty0", 32'(dut.duty[0]), 32'h8000);
        mute = 1'b0;
        tick();
        chk("unmute_duty0", 32'(dut.duty[0]), 32'hC000);

        // Underrun: last vld at edge N, flag at N+17, silence at N+18
        tick();
        vld = 1'b0;
        repeat (15) tick();
        tick();
        chk("ur_before", 32'(underrun), 32'h0);
        tick();
        chk("ur_rise", 32'(underrun), 32'h1);
        chk("ur_rise_duty0", 32'(dut.duty[0]), 32'hC000);
        tick();
        chk("ur_duty0", 32'(dut.duty[0]), 32'h8000);
        chk("ur_duty1", 32'(dut.duty[1]), 32'h8000);
        smp = {16'hFFFF, 16'hC000};
        vld = 1'b1;
        tick();
        vld = 1'b0;
        chk("ur_fall", 32'(underrun), 32'h0);
        chk("ur_fall_duty0", 32'(dut.duty[0]), 32'h8000);
        tick();
        chk("ur_new_duty0", 32'(dut.duty[0]), 32'hC000);
        chk("ur_new_duty1", 32'(dut.duty[1]), 32'hFFFF);

        // Reset mid-operation, colliding with a vld
        smp   = {16'h1234, 16'h0000};
        vld   = 1'b1;
        atten = 4'd3;
        rst   = 1'b1;
        tick();
        chk("mr_pdm", 32'(pdm), 32'h0);
        chk("mr_underrun", 32'(underrun), 32'h0);
        chk("mr_duty0", 32'(dut.duty[0]), 32'h8000);
        chk("mr_duty1", 32'(dut.duty[1]), 32'h8000);
        chk("mr_sample0", 32'(dut.sample[0]), 32'h8000);
        chk("mr_sample_s", 32'(dut_s.sample[0]), 32'h0);
        rst   = 1'b0;
        vld   = 1'b0;
        atten = 4'd0;
        tick(); chk("mr_seq0", 32'(pdm), 32'h0);
        tick(); chk("mr_seq1", 32'(pdm), 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdm_spkr_drv_mc.md
Name: pdm_spkr_drv_mc

Overview:
Multi-channel pulse-density-modulated speaker driver, and the parametrised successor of the two-channel PDM speaker driver.
- Captures one frame of NUM_CH audio samples on a valid strobe.
- Conditions each sample: signed/unsigned format, attenuation, mute, and underrun silence.
- Drives one first-order sigma-delta PDM bit per channel.
- Sits between the audio processing chain and the speaker output pins.

Parameters:
NUM_CH, 2, number of audio channels (1..8)
W, 16, sample and duty width in bits (8..24)
SIGNED_IN, 0, 0: samples are unsigned offset-binary (midscale = silence); 1: samples are two's complement
TIMEOUT, 4096, cycles without vld before underrun is declared; 0 disables underrun detection

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; synchronous, active-high
smp  input  NUM_CH*W  frame of samples; channel k at bits [k*W+W-1 : k*W]
vld  input  1  single-cycle strobe; smp is valid this cycle
atten  input  4  attenuation; arithmetic right shift of the centred sample, 0..15
mute  input  1  level; forces all channels to silence
pdm  output  NUM_CH  PDM bit per channel, registered
underrun  output  1  registered; high while no vld has arrived for TIMEOUT cycles

Behaviour:
- MID = 1 << (W-1), the silence code in offset-binary.
- Reset (rst high at a clock edge) sets:
  - all sample registers to MID when SIGNED_IN=0, or 0 when SIGNED_IN=1 (both mean silence);
  - all duty registers to MID;
  - all accumulators to 0;
  - pdm to 0, underrun to 0, and the underrun counter to 0.
- Reset mid-operation aborts everything in the same edge. No partial state survives.
- Stage 1, capture: on vld, all NUM_CH sample registers load smp at the edge. Without vld they hold.
- Stage 2, conditioning, registered into duty[k] every cycle:
  - Centre the sample: c = sample with MSB inverted if SIGNED_IN=0; c = sample unchanged if SIGNED_IN=1. c is treated as signed W-bit.
  - a = c >>> atten (arithmetic shift, sign-extended). atten=0 passes c unchanged.
  - duty = a with MSB inverted, giving offset-binary W bits.
  - If mute or underrun is high, duty = MID, taking precedence over the sample.
  - atten and mute take effect on duty one edge after they change.
- Stage 3, modulator, per channel:
  - W+1-bit sum s = acc + duty.
  - acc <= s[W-1:0]; pdm[k] <= s[W].
  - Density of pdm ones = duty / 2^W.
  - duty=0 gives constant 0. duty=2^W-1 gives a 0 once every 2^W cycles. duty=MID from acc=0 gives 0,1,0,1,...
  - The accumulator is never cleared by mute or underrun, only by rst.
- Latency: a sample captured at edge N reaches duty at edge N+1 and first affects pdm at edge N+2.
- Underrun counter:
  - vld resets the counter to 0.
  - Otherwise it increments, saturating at TIMEOUT.
  - underrun <= (counter == TIMEOUT) and no vld this cycle.
- A vld while underrun is high clears underrun at the next edge. The new sample then passes through normally.
- With TIMEOUT=0, underrun is tied 0 and the counter is removed.
- vld in consecutive cycles: every frame is accepted; the last one wins.
- vld and rst in the same cycle: rst wins.

Decomposition:
- Package pdm_spkr_pkg holds:
  - the mid-scale function mid_code(W);
  - the offset/two's-complement conversion function;
  - the counter width computed from TIMEOUT via $clog2.
- Sub-module pdm_mod, parameter W. Ports: clk, rst, duty[W-1:0], pdm. This is the stage-3 sigma-delta modulator.
- pdm_spkr_drv_mc instantiates NUM_CH copies of pdm_mod in a generate loop.

Test Plan:
1. Reset, W=16, NUM_CH=2, SIGNED_IN=0 -> duty=0x8000 on both channels; pdm sequence 0,1,0,1 from the first edge after reset release; underrun=0.
2. vld with ch0=0x0000, ch1=0xFFFF, atten=0 -> from edge N+2, pdm[0] stays 0 and pdm[1] has 65535 ones per 65536 cycles.
3. vld ch0=0xC000, atten=0 -> 75% ones over 1024 cycles; then atten=1 -> duty=0xA000, 62.5% ones; atten=15 -> duty=0x8000 (positive input shifts to 0).
4. SIGNED_IN=1, vld ch0=0x8000 (most negative), atten=2 -> duty=0x6000 (37.5% ones); ch0=0x7FFF, atten=0 -> duty=0xFFFF.
5. TIMEOUT=16: one vld, then idle -> underrun rises at the 17th edge after vld and duty=0x8000; a new vld with 0xC000 -> underrun falls the next edge and duty=0xC000.
6. mute asserted for 10 cycles with duty=0xC000 -> duty=0x8000 one edge later; release mute -> duty back to 0xC000; rst asserted mid-frame -> all registers return to their reset values at that edge.
